pc_fetch_controller: RTL and testbench

//  Owns the program counter and sequences instruction fetch for the RISC-V core.
//  - Drives the fetch address to instruction memory over a req/ready handshake.
//  - Selects the next PC: sequential, redirect (branch/jump), trap vector, or halt.
//  - Sits between execute (redirect/stall/halt sources) and instruction memory.

---
 rtl/pc_fetch_controller_if.sv | 28 ++
 rtl/pc_fetch_controller.sv | 119 +++++++++++
 tb/tb_pc_fetch_controller.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_controller_if.sv
// Fetch-controller bundle: instruction-memory handshake, execute-side controls and trap/status.
// master = controller side, slave = memory/execute side.
interface pc_fetch_controller_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            fetch_fire;
  logic [XLEN-1:0] pc_current;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            stall;
  logic            halt_req;
  logic            trap;
  logic [XLEN-1:0] trap_epc;
  logic            halted;

  modport master (
    output imem_req, imem_addr, fetch_fire, pc_current, trap, trap_epc, halted,
    input  imem_ready, redirect_valid, redirect_target, stall, halt_req
  );

  modport slave (
    input  imem_req, imem_addr, fetch_fire, pc_current, trap, trap_epc, halted,
    output imem_ready, redirect_valid, redirect_target, stall, halt_req
  );
endinterface

// File: rtl/pc_fetch_controller.sv
// PC owner and fetch sequencer: BOOT delay, then FETCH with stall/halt/redirect/pending priority.
// Redirect reaches imem_addr one cycle later; imem_ready=0 holds the PC and the request.
module pc_fetch_controller #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h100,
  parameter int              BOOT_DELAY   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  pc_fetch_controller_if.master bus
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  localparam int            CW        = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
  localparam logic [CW-1:0] BOOT_LAST = CW'((BOOT_DELAY > 0) ? BOOT_DELAY - 1 : 0);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   boot_cnt_q, boot_cnt_d;
  logic            pend_valid_q, pend_valid_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;
  logic            trap_q, trap_d;
  logic [XLEN-1:0] trap_epc_q, trap_epc_d;

  logic            req;
  logic            fire;
  logic            apply;
  logic [XLEN-1:0] apply_tgt;

  assign req  = (state_q == S_FETCH) & ~bus.stall;
  assign fire = req & bus.imem_ready;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    boot_cnt_d    = boot_cnt_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    trap_d        = 1'b0;
    trap_epc_d    = trap_epc_q;
    apply         = 1'b0;
    apply_tgt     = '0;

    case (state_q)
      S_BOOT: begin
        boot_cnt_d = boot_cnt_q + 1'b1;
        if ((BOOT_DELAY == 0) || (boot_cnt_q == BOOT_LAST)) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.stall) begin
          // Only the newest redirect seen during a stall survives.
          if (bus.redirect_valid) begin
            pend_valid_d  = 1'b1;
            pend_target_d = bus.redirect_target;
          end
        end else if (fire && bus.halt_req) begin
          state_d      = S_HALT;
          pend_valid_d = 1'b0;
        end else if (bus.redirect_valid) begin
          apply        = 1'b1;
          apply_tgt    = bus.redirect_target;
          pend_valid_d = 1'b0;
        end else if (pend_valid_q) begin
          apply        = 1'b1;
          apply_tgt    = pend_target_q;
          pend_valid_d = 1'b0;
        end else if (fire) begin
          pc_d = pc_q + XLEN'(4);
        end
      end
      default: ;
    endcase

    if (apply) begin
      if (|apply_tgt[1:0]) begin
        pc_d       = TRAP_VECTOR;
        trap_d     = 1'b1;
        trap_epc_d = apply_tgt;
      end else begin
        pc_d = apply_tgt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_VECTOR;
      boot_cnt_q    <= '0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      trap_q        <= 1'b0;
      trap_epc_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      boot_cnt_q    <= boot_cnt_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      trap_q        <= trap_d;
      trap_epc_q    <= trap_epc_d;
    end
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc_q;
  assign bus.pc_current = pc_q;
  assign bus.fetch_fire = fire;
  assign bus.trap       = trap_q;
  assign bus.trap_epc   = trap_epc_q;
  assign bus.halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Directed vector table for the boot/backpressure/redirect/stall/wrap/halt scenarios,
// then randomized traffic checked against a queue-based reference model.
module tb_pc_fetch_controller;
  localparam int          XLEN       = 32;
  localparam logic [31:0] RST_VEC    = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC   = 32'h0000_0100;
  localparam int          BOOT_DELAY = 2;
  localparam int          BOOT_CYC   = (BOOT_DELAY == 0) ? 1 : BOOT_DELAY;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_fetch_controller_if #(.XLEN(XLEN)) bus();

  pc_fetch_controller #(
    .XLEN(XLEN), .RESET_VECTOR(RST_VEC), .TRAP_VECTOR(TRAP_VEC), .BOOT_DELAY(BOOT_DELAY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        rv;
    logic [31:0] tgt;
    logic        st;
    logic        hr;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_fire;
    logic        e_trap;
    logic [31:0] e_epc;
    logic        e_halted;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: boot countdown, single-slot pending redirect held in a queue.
  int          m_boot;
  bit          m_halt;
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];
  bit          m_trap;
  logic [31:0] m_epc;

  function automatic vec_t mk(logic rv, logic [31:0] tgt, logic st, logic hr, logic rdy,
                              logic req, logic [31:0] addr, logic fire, logic trp,
                              logic [31:0] epc, logic hlt);
    vec_t v;
    v.rv = rv; v.tgt = tgt; v.st = st; v.hr = hr; v.rdy = rdy;
    v.e_req = req; v.e_addr = addr; v.e_fire = fire; v.e_trap = trp;
    v.e_epc = epc; v.e_halted = hlt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot = 0;
    m_halt = 1'b0;
    m_pc   = RST_VEC;
    m_pend.delete();
    m_trap = 1'b0;
    m_epc  = '0;
  endtask

  function automatic vec_t model_exp(input vec_t v);
    vec_t e;
    bit   active;
    e = v;
    active     = (m_boot >= BOOT_CYC) && !m_halt;
    e.e_req    = active && !v.st;
    e.e_fire   = e.e_req && v.rdy;
    e.e_addr   = m_pc;
    e.e_trap   = m_trap;
    e.e_epc    = m_epc;
    e.e_halted = m_halt;
    return e;
  endfunction

  task automatic model_goto(input logic [31:0] t);
    if (t % 4 != 0) begin
      m_pc   = TRAP_VEC;
      m_trap = 1'b1;
      m_epc  = t;
    end else begin
      m_pc = t;
    end
  endtask

  task automatic model_step(input vec_t v);
    bit fired;
    fired  = (m_boot >= BOOT_CYC) && !m_halt && !v.st && v.rdy;
    m_trap = 1'b0;
    if (m_boot < BOOT_CYC) begin
      m_boot++;
    end else if (!m_halt) begin
      if (v.st) begin
        if (v.rv) begin
          m_pend.delete();
          m_pend.push_back(v.tgt);
        end
      end else if (fired && v.hr) begin
        m_halt = 1'b1;
        m_pend.delete();
      end else if (v.rv) begin
        m_pend.delete();
        model_goto(v.tgt);
      end else if (m_pend.size() > 0) begin
        model_goto(m_pend.pop_front());
      end else if (fired) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check_outputs(input vec_t e);
    chk("imem_req",   {31'b0, bus.imem_req},   {31'b0, e.e_req});
    chk("imem_addr",  bus.imem_addr,           e.e_addr);
    chk("pc_current", bus.pc_current,          e.e_addr);
    chk("fetch_fire", {31'b0, bus.fetch_fire}, {31'b0, e.e_fire});
    chk("trap",       {31'b0, bus.trap},       {31'b0, e.e_trap});
    chk("trap_epc",   bus.trap_epc,            e.e_epc);
    chk("halted",     {31'b0, bus.halted},     {31'b0, e.e_halted});
  endtask

  // Called at a negedge: drive, sample mid-low-phase, advance through the rising edge.
  task automatic cycle(input vec_t v, input bit use_table);
    vec_t e;
    bus.redirect_valid  = v.rv;
    bus.redirect_target = v.tgt;
    bus.stall           = v.st;
    bus.halt_req        = v.hr;
    bus.imem_ready      = v.rdy;
    #1;
    e = use_table ? v : model_exp(v);
    check_outputs(e);
    @(posedge clk);
    model_step(v);
    @(negedge clk);
  endtask

  // Asserts rst away from any clock edge and checks the asynchronous clear immediately.
  task automatic do_reset(input int hold);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_imem_req",   {31'b0, bus.imem_req},   32'd0);
    chk("rst_imem_addr",  bus.imem_addr,           RST_VEC);
    chk("rst_pc_current", bus.pc_current,          RST_VEC);
    chk("rst_fetch_fire", {31'b0, bus.fetch_fire}, 32'd0);
    chk("rst_trap",       {31'b0, bus.trap},       32'd0);
    chk("rst_trap_epc",   bus.trap_epc,            32'd0);
    chk("rst_halted",     {31'b0, bus.halted},     32'd0);
    repeat (hold) @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vecs[20];

  initial begin
    vec_t v;
    int   halt_cycles;

    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.stall           = 1'b0;
    bus.halt_req        = 1'b0;
    bus.imem_ready      = 1'b0;

    //            rv tgt            st hr rdy | req addr          fire trap epc           halted
    vecs[0]  = mk(1, 32'h0000_0040, 0, 0, 1,    0, 32'h0000_0000, 0,   0,   32'h0,        0);
    vecs[1]  = mk(1, 32'h0000_0041, 0, 0, 1,    0, 32'h0000_0000, 0,   0,   32'h0,        0);
    vecs[2]  = mk(0, 32'h0,         0, 0, 1,    1, 32'h0000_0000, 1,   0,   32'h0,        0);
    vecs[3]  = mk(0, 32'h0,         0, 0, 1,    1, 32'h0000_0004, 1,   0,   32'h0,        0);
    vecs[4]  = mk(0, 32'h0,         0, 0, 0,    1, 32'h0000_0008, 0,   0,   32'h0,        0);
    vecs[5]  = mk(0, 32'h0,         0, 0, 0,    1, 32'h0000_0008, 0,   0,   32'h0,        0);
    vecs[6]  = mk(0, 32'h0,         0, 0, 0,    1, 32'h0000_0008, 0,   0,   32'h0,        0);
    vecs[7]  = mk(0, 32'h0,         0, 0, 1,    1, 32'h0000_0008, 1,   0,   32'h0,        0);
    vecs[8]  = mk(1, 32'h0000_0200, 0, 0, 1,    1, 32'h0000_000C, 1,   0,   32'h0,        0);
    vecs[9]  = mk(1, 32'h0000_0202, 0, 0, 1,    1, 32'h0000_0200, 1,   0,   32'h0,        0);
    vecs[10] = mk(0, 32'h0,         0, 0, 0,    1, 32'h0000_0100, 0,   1,   32'h0000_0202, 0);
    vecs[11] = mk(0, 32'h0,         0, 0, 0,    1, 32'h0000_0100, 0,   0,   32'h0000_0202, 0);
    vecs[12] = mk(1, 32'h0000_0040, 1, 0, 1,    0, 32'h0000_0100, 0,   0,   32'h0000_0202, 0);
    vecs[13] = mk(1, 32'h0000_0080, 1, 0, 1,    0, 32'h0000_0100, 0,   0,   32'h0000_0202, 0);
    vecs[14] = mk(0, 32'h0,         0, 0, 1,    1, 32'h0000_0100, 1,   0,   32'h0000_0202, 0);
    vecs[15] = mk(1, 32'hFFFF_FFFC, 0, 0, 1,    1, 32'h0000_0080, 1,   0,   32'h0000_0202, 0);
    vecs[16] = mk(0, 32'h0,         0, 0, 1,    1, 32'hFFFF_FFFC, 1,   0,   32'h0000_0202, 0);
    vecs[17] = mk(1, 32'h0000_0300, 0, 1, 1,    1, 32'h0000_0000, 1,   0,   32'h0000_0202, 0);
    vecs[18] = mk(1, 32'h0000_0500, 0, 0, 1,    0, 32'h0000_0000, 0,   0,   32'h0000_0202, 1);
    vecs[19] = mk(0, 32'h0,         0, 1, 1,    0, 32'h0000_0000, 0,   0,   32'h0000_0202, 1);

    @(negedge clk);
    do_reset(3);
    for (int i = 0; i < 20; i++) begin
      cycle(vecs[i], 1'b1);
    end
    do_reset(2);

    halt_cycles = 0;
    for (int n = 0; n < 3000; n++) begin
      if ((n % 250 == 249) || (halt_cycles > 8)) begin
        do_reset(1 + $urandom_range(0, 2));
        halt_cycles = 0;
      end
      v.rv  = ($urandom_range(0, 3) == 0);
      v.tgt = $urandom;
      if ($urandom_range(0, 3) != 0) v.tgt[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) v.tgt = 32'hFFFF_FFFC;
      v.st  = ($urandom_range(0, 4) == 0);
      v.hr  = ($urandom_range(0, 60) == 0);
      v.rdy = ($urandom_range(0, 2) != 0);
      v.e_req = 1'b0; v.e_addr = '0; v.e_fire = 1'b0;
      v.e_trap = 1'b0; v.e_epc = '0; v.e_halted = 1'b0;
      cycle(v, 1'b0);
      if (m_halt) halt_cycles++;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
